io_input_conditioner: RTL and testbench

Front-end conditioning stage for the board's user inputs, sitting directly upstream of the CPU's memory-mapped IO read/write module. Synchronizes and debounces the 8 data switches, 3 test switches and the two "enter" push-buttons, and delivers stable switch buses plus single-cycle `enterA` / `enterB` load strobes. The IO module latches `IO_input` into its A/B registers on those strobes and returns `TEST_input` on reads of the test address.

---
 rtl/io_input_conditioner.sv | 145 ++++++++++++++
 tb/tb_io_input_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: 2-flop sync + debounce of user switches and buttons.
// Emits stable switch buses and one-cycle enterA/enterB load strobes.
module io_btn_stage #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clock,
  input  logic rst_n,
  input  logic btn,
  output logic strobe
);
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      strobe <= (state_nx == PRESSED);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (btn) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn)
          state_nx = IDLE;
        else if (cnt == LAST)
          state_nx = PRESSED;
        else
          cnt_nx = cnt + CNT_W'(1);
      end
      PRESSED: begin
        state_nx = RELEASE_WAIT;
        cnt_nx   = '0;
      end
      RELEASE_WAIT: begin
        // any bounce high restarts the release wait
        if (btn)
          cnt_nx = '0;
        else if (cnt == LAST)
          state_nx = IDLE;
        else
          cnt_nx = cnt + CNT_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] sw_data,
  input  logic [2:0] sw_test,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic [7:0] IO_input,
  output logic [2:0] TEST_input,
  output logic       enterA,
  output logic       enterB
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [12:0] sync1, sync2;
  logic [10:0] s_sw;
  logic        s_btn_a, s_btn_b;
  logic [10:0] cand;
  logic [CNT_W-1:0] sw_cnt;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_b, btn_a, sw_test, sw_data};
      sync2 <= sync1;
    end
  end

  assign s_sw    = sync2[10:0];
  assign s_btn_a = sync2[11];
  assign s_btn_b = sync2[12];

  // whole switch bus shares one candidate so any bit change restarts it
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cand       <= '0;
      sw_cnt     <= '0;
      IO_input   <= '0;
      TEST_input <= '0;
    end else if (s_sw != cand) begin
      cand   <= s_sw;
      sw_cnt <= '0;
    end else if (sw_cnt == LAST) begin
      {TEST_input, IO_input} <= cand;
    end else begin
      sw_cnt <= sw_cnt + CNT_W'(1);
    end
  end

  io_btn_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_btn_a (
    .clock(clock),
    .rst_n(rst_n),
    .btn(s_btn_a),
    .strobe(enterA)
  );

  io_btn_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_btn_b (
    .clock(clock),
    .rst_n(rst_n),
    .btn(s_btn_b),
    .strobe(enterB)
  );
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: directed scenarios plus random stimulus
// checked every cycle against a windowed history model.
module tb_io_input_conditioner;
  localparam int D = 4;
  localparam int MAXC = 4096;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [7:0] sw_data;
  logic [2:0] sw_test;
  logic       btn_a, btn_b;
  logic [7:0] IO_input;
  logic [2:0] TEST_input;
  logic       enterA, enterB;

  io_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .sw_data(sw_data),
    .sw_test(sw_test),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .IO_input(IO_input),
    .TEST_input(TEST_input),
    .enterA(enterA),
    .enterB(enterB)
  );

  always #5 clock = ~clock;

  // per-edge history: raw sample, reset flag, value seen by logic
  logic [12:0] raw [MAXC];
  bit          rs  [MAXC];
  logic [12:0] v   [MAXC];
  int k = 0;

  logic [10:0] m_sw = '0;
  bit m_en [2];
  bit armed [2];
  int idle_since [2];
  int last_strobe [2];

  int n_chk = 0;
  int n_fail = 0;
  int seg_i, cnt_a, cnt_b, pos_a, pos_b;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h",
               tag, $time, got, exp);
    end
  endtask

  // switches: output follows a value held for D+1 consecutive
  // logic-side samples. buttons: strobe after D+1 ones while armed,
  // re-arm after D zeros following the strobe cycle.
  task automatic model_edge();
    bit ok;
    if (rs[k]) begin
      m_sw = '0;
      v[k] = '0;
      for (int b = 0; b < 2; b++) begin
        m_en[b] = 1'b0;
        armed[b] = 1'b1;
        idle_since[b] = k + 1;
      end
      return;
    end
    if (k < 2 || rs[k-1] || rs[k-2]) v[k] = '0;
    else v[k] = raw[k-2];
    if (k >= D) begin
      ok = 1'b1;
      for (int i = 1; i <= D; i++)
        if (rs[k-i] || v[k-i][10:0] != v[k][10:0]) ok = 1'b0;
      if (ok) m_sw = v[k][10:0];
    end
    for (int b = 0; b < 2; b++) begin
      m_en[b] = 1'b0;
      if (armed[b]) begin
        if (k - D >= idle_since[b]) begin
          ok = 1'b1;
          for (int i = 0; i <= D; i++)
            if (!v[k-i][11+b]) ok = 1'b0;
          if (ok) begin
            m_en[b] = 1'b1;
            armed[b] = 1'b0;
            last_strobe[b] = k;
          end
        end
      end else if (k - D + 1 >= last_strobe[b] + 2) begin
        ok = 1'b1;
        for (int i = 0; i < D; i++)
          if (v[k-i][11+b]) ok = 1'b0;
        if (ok) begin
          armed[b] = 1'b1;
          idle_since[b] = k + 1;
        end
      end
    end
  endtask

  task automatic seg_start();
    seg_i = 0;
    cnt_a = 0;
    cnt_b = 0;
    pos_a = -1;
    pos_b = -1;
  endtask

  task automatic step(input bit r, input logic [7:0] d,
                      input logic [2:0] t, input bit a, input bit b);
    @(negedge clock);
    rst_n = r;
    sw_data = d;
    sw_test = t;
    btn_a = a;
    btn_b = b;
    @(posedge clock);
    raw[k] = {b, a, t, d};
    rs[k] = !r;
    model_edge();
    #1;
    check("io", IO_input, m_sw[7:0]);
    check("test", TEST_input, m_sw[10:8]);
    check("en_a", enterA, m_en[0]);
    check("en_b", enterB, m_en[1]);
    if (enterA) begin cnt_a++; pos_a = seg_i; end
    if (enterB) begin cnt_b++; pos_b = seg_i; end
    seg_i++;
    k++;
  endtask

  task automatic idle_steps(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) step(1, d, 3'd0, 0, 0);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] rt;
    bit ra, rb, rr;
    rst_n = 1'b0;
    sw_data = '0;
    sw_test = '0;
    btn_a = 1'b0;
    btn_b = 1'b0;

    // reset with all inputs high
    seg_start();
    for (int i = 0; i < 3; i++) begin
      step(0, 8'hFF, 3'h7, 1, 1);
      check("rst_outs", {IO_input, TEST_input, enterA, enterB}, 0);
    end
    seg_start();
    for (int i = 0; i < 10; i++) begin
      step(1, 8'hFF, 3'h7, 1, 1);
      if (i == 5) check("rst_io_early", IO_input, 0);
      if (i == 6) begin
        check("rst_io", IO_input, 8'hFF);
        check("rst_test", TEST_input, 3'h7);
      end
    end
    check("rst_cnt_a", cnt_a, 1);
    check("rst_cnt_b", cnt_b, 1);
    check("rst_pos_a", pos_a, 6);
    check("rst_pos_b", pos_b, 6);
    idle_steps(12, 8'h00);

    // clean press on A
    seg_start();
    for (int i = 0; i < 40; i++) step(1, 8'h00, 3'd0, 1, 0);
    check("clean_cnt_a", cnt_a, 1);
    check("clean_pos_a", pos_a, 6);
    check("clean_cnt_b", cnt_b, 0);
    idle_steps(12, 8'h00);

    // bouncy press on B: 1,0,1,1,0 then steady
    seg_start();
    for (int i = 0; i < 25; i++)
      step(1, 8'h00, 3'd0, 0, (i < 5) ? (i != 1 && i != 4) : 1'b1);
    check("bounce_cnt_b", cnt_b, 1);
    check("bounce_pos_b", pos_b, 11);
    check("bounce_cnt_a", cnt_a, 0);
    idle_steps(12, 8'h00);

    // short release does not re-arm; long release does
    seg_start();
    for (int i = 0; i < 10; i++) step(1, 8'h00, 3'd0, 1, 0);
    for (int i = 0; i < 2; i++) step(1, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h00, 3'd0, 1, 0);
    check("rel_short_cnt", cnt_a, 1);
    seg_start();
    for (int i = 0; i < 8; i++) step(1, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'h00, 3'd0, 1, 0);
    check("rel_long_cnt", cnt_a, 1);
    check("rel_long_pos", pos_a, 14);
    idle_steps(12, 8'h00);

    // switch glitch mid-count
    seg_start();
    for (int i = 0; i < 15; i++) begin
      step(1, (i == 3) ? 8'h5B : 8'h5A, 3'd0, 0, 0);
      check("glitch_never", IO_input == 8'h5B, 0);
      if (i == 9) check("glitch_early", IO_input, 8'h00);
      if (i == 10) check("glitch_io", IO_input, 8'h5A);
    end

    // simultaneous presses
    seg_start();
    for (int i = 0; i < 10; i++) step(1, 8'h5A, 3'd0, 1, 1);
    check("simul_cnt_a", cnt_a, 1);
    check("simul_cnt_b", cnt_b, 1);
    check("simul_same", pos_a, pos_b);
    check("simul_pos", pos_a, 6);
    idle_steps(12, 8'h5A);

    // reset in the middle of PRESS_WAIT
    seg_start();
    for (int i = 0; i < 3; i++) step(1, 8'h5A, 3'd0, 1, 1);
    step(0, 8'h5A, 3'd0, 0, 0);
    check("midrst_outs", {IO_input, TEST_input, enterA, enterB}, 0);
    idle_steps(12, 8'h5A);
    check("midrst_cnt_a", cnt_a, 0);
    check("midrst_cnt_b", cnt_b, 0);

    // random stimulus
    rd = 8'h5A;
    rt = 3'd0;
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) ra = !ra;
      if ($urandom_range(7) == 0) rb = !rb;
      if ($urandom_range(9) == 0) {rt, rd} = 11'($urandom);
      rr = ($urandom_range(299) != 0);
      step(rr, rd, rt, ra, rb);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
